// File: rtl/ps2_cmd_sequencer.sv
// Host-to-keyboard command sequencer for PS2_Controller: sends command/argument bytes,
// handles FA/FE/AA/FC responses with retry and timeouts, and filters them from the scancode stream.
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int BAT_TIMEOUT = 50_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       cmd_ready,
  output logic       done,
  output logic [1:0] status,
  input  logic [7:0] ps2_rx_data,
  input  logic       ps2_rx_en,
  input  logic       ps2_cmd_sent,
  input  logic       ps2_cmd_timeout,
  output logic [7:0] ps2_command,
  output logic       ps2_send_command,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic [2:0] o_dbg_state
);

  localparam int          RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [25:0] ACK_LIM   = 26'(ACK_TIMEOUT - 1);
  localparam logic [25:0] BAT_LIM   = 26'(BAT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_CMD, S_ACK_CMD, S_SEND_ARG, S_ACK_ARG, S_WAIT_BAT, S_FINISH
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_cmd, r_arg;
  logic          r_has_arg;
  logic [RW-1:0] r_retry, w_retry_nxt, w_retry_inc;
  logic [25:0]   r_cnt;
  logic [1:0]    r_status, w_fin_status;
  logic [7:0]    r_key_data;
  logic          r_key_valid;
  logic          w_rx_fa, w_rx_fe, w_rx_aa, w_rx_fc, w_rx_proto;

  assign w_rx_fa     = ps2_rx_en && (ps2_rx_data == 8'hFA);
  assign w_rx_fe     = ps2_rx_en && (ps2_rx_data == 8'hFE);
  assign w_rx_aa     = ps2_rx_en && (ps2_rx_data == 8'hAA);
  assign w_rx_fc     = ps2_rx_en && (ps2_rx_data == 8'hFC);
  assign w_rx_proto  = ps2_rx_data inside {8'hFA, 8'hFE, 8'hAA, 8'hFC};
  assign w_retry_inc = r_retry + 1'b1;

  // Handshake: a command transfers on any edge where cmd_valid && cmd_ready; the requester holds cmd_valid until then.
  always_comb begin
    w_state_nxt  = r_state;
    w_retry_nxt  = r_retry;
    w_fin_status = r_status;
    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = S_SEND_CMD;
          w_retry_nxt = '0;
        end
      end
      S_SEND_CMD, S_SEND_ARG: begin
        if (ps2_cmd_timeout) begin
          w_state_nxt  = S_FINISH;
          w_fin_status = 2'b10;
        end else if (ps2_cmd_sent) begin
          w_state_nxt = (r_state == S_SEND_CMD) ? S_ACK_CMD : S_ACK_ARG;
        end
      end
      S_ACK_CMD, S_ACK_ARG: begin
        if (w_rx_fa) begin
          w_retry_nxt  = '0;
          w_fin_status = 2'b00;
          if (r_state == S_ACK_ARG)  w_state_nxt = S_FINISH;
          else if (r_has_arg)        w_state_nxt = S_SEND_ARG;
          else if (r_cmd == 8'hFF)   w_state_nxt = S_WAIT_BAT;
          else                       w_state_nxt = S_FINISH;
        end else if (w_rx_fe) begin
          w_retry_nxt = w_retry_inc;
          if (w_retry_inc <= RETRY_MAX) begin
            w_state_nxt = (r_state == S_ACK_CMD) ? S_SEND_CMD : S_SEND_ARG;
          end else begin
            w_state_nxt  = S_FINISH;
            w_fin_status = 2'b01;
          end
        end else if (r_cnt >= ACK_LIM) begin
          w_state_nxt  = S_FINISH;
          w_fin_status = 2'b10;
        end
      end
      S_WAIT_BAT: begin
        if (w_rx_aa) begin
          w_state_nxt  = S_FINISH;
          w_fin_status = 2'b00;
        end else if (w_rx_fc) begin
          w_state_nxt  = S_FINISH;
          w_fin_status = 2'b11;
        end else if (r_cnt >= BAT_LIM) begin
          w_state_nxt  = S_FINISH;
          w_fin_status = 2'b10;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_arg       <= '0;
      r_has_arg   <= 1'b0;
      r_retry     <= '0;
      r_cnt       <= '0;
      r_status    <= 2'b00;
      r_key_data  <= '0;
      r_key_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      if (r_state == S_IDLE && cmd_valid) begin
        r_cmd     <= cmd_byte;
        r_arg     <= cmd_arg;
        r_has_arg <= cmd_has_arg;
      end
      // Timeout counter restarts on every state change and saturates rather than wrapping.
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != '1)       r_cnt <= r_cnt + 26'd1;
      if (w_state_nxt == S_FINISH && r_state != S_FINISH) r_status <= w_fin_status;
      r_key_valid <= ps2_rx_en && (!w_rx_proto || r_state == S_IDLE);
      if (ps2_rx_en && (!w_rx_proto || r_state == S_IDLE)) r_key_data <= ps2_rx_data;
    end
  end

  assign cmd_ready        = (r_state == S_IDLE);
  assign done             = (r_state == S_FINISH);
  assign status           = r_status;
  assign ps2_send_command = (r_state == S_SEND_CMD) || (r_state == S_SEND_ARG);
  assign ps2_command      = (r_state == S_SEND_ARG) ? r_arg : r_cmd;
  assign key_data         = r_key_data;
  assign key_valid        = r_key_valid;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Randomized scoreboard bench for ps2_cmd_sequencer: a keyboard responder plays scripted
// responses while a monitor checks transmitted bytes, completion status and forwarded scancodes.
module tb_ps2_cmd_sequencer;
  localparam int ACK_T = 50;
  localparam int BAT_T = 100;
  localparam int MAX_R = 3;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic       cmd_has_arg = 1'b0;
  logic [7:0] cmd_arg = '0;
  logic [7:0] ps2_rx_data = '0;
  logic       ps2_rx_en = 1'b0;
  logic       ps2_cmd_sent = 1'b0;
  logic       ps2_cmd_timeout = 1'b0;
  logic       cmd_ready, done, ps2_send_command, key_valid;
  logic [1:0] status;
  logic [7:0] ps2_command, key_data;
  logic [2:0] dbg_state;

  ps2_cmd_sequencer #(.ACK_TIMEOUT(ACK_T), .BAT_TIMEOUT(BAT_T), .MAX_RETRY(MAX_R)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .cmd_ready(cmd_ready), .done(done), .status(status),
    .ps2_rx_data(ps2_rx_data), .ps2_rx_en(ps2_rx_en),
    .ps2_cmd_sent(ps2_cmd_sent), .ps2_cmd_timeout(ps2_cmd_timeout),
    .ps2_command(ps2_command), .ps2_send_command(ps2_send_command),
    .key_data(key_data), .key_valid(key_valid), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] exp_tx_q[$];
  logic [1:0] exp_st_q[$];
  logic [7:0] exp_key_q[$];
  logic       mon_prev_send, mon_prev_kv;

  typedef struct {
    logic [7:0] cmd;
    logic       has_arg;
    logic [7:0] arg;
    int         nfe0, nfe1;
    bit         sil0, sil1;
    int         bat;       // 0: AA, 1: FC, 2: no response
    bit         tx_to;
    bit         rx_acc;
    bit         force_sc;
  } plan_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got %0h expected nothing", name, act);
  endtask

  function automatic bit is_proto(input logic [7:0] b);
    return b inside {8'hFA, 8'hFE, 8'hAA, 8'hFC};
  endfunction

  // Reference model: what the keyboard script implies the host must send and report.
  task automatic model_push(input plan_t p);
    int nbytes;
    logic [7:0] b;
    logic [1:0] st;
    bit stop;
    int nfe;
    bit sil;
    st = 2'b00;
    stop = 0;
    if (p.tx_to) begin
      exp_tx_q.push_back(p.cmd);
      exp_st_q.push_back(2'b10);
      return;
    end
    nbytes = p.has_arg ? 2 : 1;
    for (int i = 0; i < nbytes && !stop; i++) begin
      b   = (i == 0) ? p.cmd : p.arg;
      nfe = (i == 0) ? p.nfe0 : p.nfe1;
      sil = (i == 0) ? p.sil0 : p.sil1;
      for (int a = 0; a <= nfe && a <= MAX_R; a++) exp_tx_q.push_back(b);
      if (nfe > MAX_R) begin st = 2'b01; stop = 1; end
      else if (sil)    begin st = 2'b10; stop = 1; end
    end
    if (!stop && !p.has_arg && p.cmd == 8'hFF)
      st = (p.bat == 0) ? 2'b00 : (p.bat == 1) ? 2'b11 : 2'b10;
    exp_st_q.push_back(st);
  endtask

  // ---------------- monitor ----------------
  initial begin
    mon_prev_send = 1'b0;
    mon_prev_kv = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (!resetn) begin
        mon_prev_send = 1'b0;
        mon_prev_kv = 1'b0;
      end else begin
        if (ps2_send_command && !mon_prev_send) begin
          if (exp_tx_q.size() == 0) fail_now("tx_unexpected", ps2_command);
          else check("tx_byte", ps2_command, exp_tx_q.pop_front());
        end
        if (done) begin
          if (exp_st_q.size() == 0) fail_now("done_unexpected", status);
          else check("done_status", status, exp_st_q.pop_front());
        end
        if (key_valid) begin
          if (mon_prev_kv) fail_now("key_valid_width", key_data);
          if (exp_key_q.size() == 0) fail_now("key_unexpected", key_data);
          else check("key_data", key_data, exp_key_q.pop_front());
        end
        mon_prev_send = ps2_send_command;
        mon_prev_kv = key_valid;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    tick();
    ps2_rx_data = b;
    ps2_rx_en = 1'b1;
    tick();
    ps2_rx_en = 1'b0;
  endtask

  task automatic pulse_sent();
    tick();
    ps2_cmd_sent = 1'b1;
    tick();
    ps2_cmd_sent = 1'b0;
  endtask

  task automatic wait_send(output bit ok);
    int n = 0;
    while (!ps2_send_command && n < 20) begin tick(); n++; end
    ok = ps2_send_command;
    if (!ok) fail_now("send_wait_timeout", 32'(n));
  endtask

  task automatic gap(input bit in_bat, input bit force_sc);
    logic [7:0] b;
    if (force_sc) begin
      exp_key_q.push_back(8'h1C);
      rx_byte(8'h1C);
    end
    repeat ($urandom_range(0, 3)) tick();
    if ($urandom_range(0, 1) == 1) begin
      do b = 8'($urandom_range(0, 255)); while (is_proto(b));
      exp_key_q.push_back(b);
      rx_byte(b);
    end
    if (in_bat && $urandom_range(0, 3) == 0) rx_byte(($urandom_range(0, 1) == 1) ? 8'hFA : 8'hFE);
  endtask

  // Counts cycles from the current one (k=1) until done is seen.
  task automatic wait_done(input int exp_k, input string name, output bit ok);
    int k = 1;
    while (!done && k < exp_k + 20) begin tick(); k++; end
    ok = done;
    check(name, 32'(k), 32'(exp_k));
    tick();
    check("ready_after_done", cmd_ready, 1'b1);
  endtask

  task automatic recover();
    tick();
    resetn = 1'b0;
    ps2_rx_en = 1'b0; ps2_cmd_sent = 1'b0; ps2_cmd_timeout = 1'b0; cmd_valid = 1'b0;
    tick(); tick();
    exp_tx_q.delete(); exp_st_q.delete(); exp_key_q.delete();
    resetn = 1'b1;
    tick();
  endtask

  task automatic issue(input plan_t p);
    tick();
    cmd_valid = 1'b1;
    cmd_byte = p.cmd;
    cmd_has_arg = p.has_arg;
    cmd_arg = p.arg;
    if (p.rx_acc) begin
      exp_key_q.push_back(8'hFA);
      ps2_rx_data = 8'hFA;
      ps2_rx_en = 1'b1;
    end
    tick();
    cmd_valid = 1'b0;
    ps2_rx_en = 1'b0;
    check("send_after_accept", ps2_send_command, 1'b1);
  endtask

  task automatic play(input plan_t p);
    bit ok;
    int nbytes, nfe;
    bit sil;
    model_push(p);
    issue(p);
    if (p.tx_to) begin
      tick(); ps2_cmd_timeout = 1'b1; tick(); ps2_cmd_timeout = 1'b0;
      wait_done(1, "done_after_tx_timeout", ok);
      if (!ok) recover();
      return;
    end
    nbytes = p.has_arg ? 2 : 1;
    for (int i = 0; i < nbytes; i++) begin
      nfe = (i == 0) ? p.nfe0 : p.nfe1;
      sil = (i == 0) ? p.sil0 : p.sil1;
      for (int a = 0; ; a++) begin
        wait_send(ok);
        if (!ok) begin recover(); return; end
        pulse_sent();
        check("send_drop_after_sent", ps2_send_command, 1'b0);
        if (a < nfe) begin
          gap(1'b0, 1'b0);
          rx_byte(8'hFE);
          if (a == MAX_R) begin
            wait_done(1, "done_after_retry_limit", ok);
            if (!ok) recover();
            return;
          end
          check("resend_reassert", ps2_send_command, 1'b1);
          continue;
        end
        if (sil) begin
          wait_done(ACK_T + 1, "ack_timeout_latency", ok);
          if (!ok) recover();
          return;
        end
        gap(1'b0, p.force_sc && i == 0);
        rx_byte(8'hFA);
        break;
      end
    end
    if (!p.has_arg && p.cmd == 8'hFF) begin
      if (p.bat == 2) wait_done(BAT_T + 1, "bat_timeout_latency", ok);
      else begin
        gap(1'b1, 1'b0);
        rx_byte((p.bat == 0) ? 8'hAA : 8'hFC);
        wait_done(1, "done_after_bat", ok);
      end
    end else wait_done(1, "done_after_final_fa", ok);
    if (!ok) recover();
  endtask

  function automatic plan_t base_plan(input logic [7:0] c, input logic ha, input logic [7:0] arg);
    plan_t p;
    p.cmd = c; p.has_arg = ha; p.arg = arg;
    p.nfe0 = 0; p.nfe1 = 0; p.sil0 = 0; p.sil1 = 0;
    p.bat = 0; p.tx_to = 0; p.rx_acc = 0; p.force_sc = 0;
    return p;
  endfunction

  function automatic int rand_nfe();
    return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
  endfunction

  function automatic plan_t rand_plan();
    plan_t p;
    logic [7:0] cmds [7];
    cmds = '{8'hED, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hEE, 8'hFF};
    p = base_plan(cmds[$urandom_range(0, 6)], 1'b0, 8'($urandom_range(0, 255)));
    p.has_arg = (p.cmd == 8'hED || p.cmd == 8'hF3);
    p.nfe0 = rand_nfe();
    p.nfe1 = rand_nfe();
    p.sil0 = ($urandom_range(0, 9) == 0);
    p.sil1 = ($urandom_range(0, 9) == 0);
    p.bat = int'($urandom_range(0, 2));
    p.tx_to = ($urandom_range(0, 19) == 0);
    p.rx_acc = ($urandom_range(0, 7) == 0);
    p.force_sc = ($urandom_range(0, 3) == 0);
    return p;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    plan_t p;
    #12;
    check("rst_send", ps2_send_command, 1'b0);
    check("rst_command", ps2_command, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_status", status, 2'b00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_data", key_data, 8'h00);
    tick();
    resetn = 1'b1;
    tick();
    check("rst_ready", cmd_ready, 1'b1);

    play(base_plan(8'hED, 1'b1, 8'h07));
    p = base_plan(8'hF4, 1'b0, 8'h00); p.nfe0 = 2; play(p);
    p = base_plan(8'hF4, 1'b0, 8'h00); p.nfe0 = 4; play(p);
    p = base_plan(8'hFF, 1'b0, 8'h00); p.bat = 0; play(p);
    p = base_plan(8'hFF, 1'b0, 8'h00); p.bat = 2; play(p);
    p = base_plan(8'hF4, 1'b0, 8'h00); p.sil0 = 1; play(p);
    p = base_plan(8'hF4, 1'b0, 8'h00); p.tx_to = 1; play(p);
    p = base_plan(8'hF3, 1'b1, 8'h20); p.rx_acc = 1; p.force_sc = 1; play(p);

    exp_key_q.push_back(8'hFA); rx_byte(8'hFA);
    exp_key_q.push_back(8'hAA); rx_byte(8'hAA);
    exp_key_q.push_back(8'h5A); rx_byte(8'h5A);
    tick(); tick();

    p = base_plan(8'hFF, 1'b0, 8'h00); p.bat = 1; play(p);

    // reset while the argument byte is being transmitted
    exp_tx_q.push_back(8'hED);
    exp_tx_q.push_back(8'h07);
    issue(base_plan(8'hED, 1'b1, 8'h07));
    begin
      bit ok;
      wait_send(ok);
      pulse_sent();
      rx_byte(8'hFA);
    end
    check("arg_send_asserted", ps2_send_command, 1'b1);
    check("arg_command", ps2_command, 8'h07);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_send", ps2_send_command, 1'b0);
    check("async_rst_command", ps2_command, 8'h00);
    check("async_rst_done", done, 1'b0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_status", status, 2'b00);
    play(base_plan(8'hF4, 1'b0, 8'h00));

    repeat (30) play(rand_plan());

    repeat (4) tick();
    check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
    check("status_queue_empty", 32'(exp_st_q.size()), 32'd0);
    check("key_queue_empty", 32'(exp_key_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
# ps2_cmd_sequencer

Sequences host-to-keyboard commands (set LEDs, set typematic, reset, and similar) through the PS2_Controller's transmit path. It handles the acknowledge, resend and self-test responses, then reports completion to the requester. It sits between game/control logic and PS2_Controller, and removes protocol response bytes from the received stream so only scancodes reach the scancode consumers.

## Interface
- ACK_TIMEOUT, 1_000_000: cycles to wait for FA/FE after a byte is sent (20 ms at 50 MHz).
- BAT_TIMEOUT, 50_000_000: cycles to wait for the self-test result after an FF reset command is acknowledged.
- MAX_RETRY, 3: FE resends allowed per byte before the command fails.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  requester has a command.
- cmd_byte  in  8  command byte.
- cmd_has_arg  in  1  command carries one argument byte.
- cmd_arg  in  8  argument byte.
- cmd_ready  out  1  block is idle and accepts a command.
- done  out  1  one-cycle pulse when a command finishes.
- status  out  2  result of the last command: 00 ok, 01 resend limit exceeded, 10 timeout, 11 self-test fail (FC). Held until the next done.
- ps2_rx_data  in  8  PS2_Controller received_data.
- ps2_rx_en  in  1  PS2_Controller received_data_en.
- ps2_cmd_sent  in  1  PS2_Controller command_was_sent pulse.
- ps2_cmd_timeout  in  1  PS2_Controller error_communication_timed_out pulse.
- ps2_command  out  8  byte to transmit.
- ps2_send_command  out  1  transmit request (level).
- key_data  out  8  forwarded scancode byte.
- key_valid  out  1  one-cycle strobe for key_data.

## Operation
- States: IDLE, SEND_CMD, ACK_CMD, SEND_ARG, ACK_ARG, WAIT_BAT, FINISH.
- IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_byte, cmd_has_arg and cmd_arg, then go to SEND_CMD.
- SEND_CMD / SEND_ARG:
  - ps2_command = latched byte; ps2_send_command=1.
  - On ps2_cmd_sent, go to ACK_CMD / ACK_ARG.
  - On ps2_cmd_timeout, finish with status 10.
- ACK_CMD / ACK_ARG:
  - Received FA: clear the retry count. From ACK_CMD go to SEND_ARG if has_arg, else to WAIT_BAT if cmd_byte==FF, else finish 00. From ACK_ARG finish 00.
  - Received FE: increment the retry count. If count ≤ MAX_RETRY, return to the matching SEND state with the same byte; otherwise finish 01.
  - No FA/FE within ACK_TIMEOUT cycles of state entry: finish 10.
- WAIT_BAT: received AA finishes 00; received FC finishes 11; BAT_TIMEOUT elapsed finishes 10.
- FINISH: done=1 for one cycle, status updated, then return to IDLE.
- Forwarding rules:
  - Every received byte except FA, FE, AA and FC is forwarded on key_data/key_valid in all states.
  - FA/FE/AA/FC are forwarded only in IDLE; outside IDLE they are consumed.
- The timeout counter is 26 bits. It clears on every state entry and saturates; it never wraps.
- Reset (asynchronous, any state, including mid-transmit): state IDLE; ps2_send_command=0, ps2_command=00, done=0, status=00, key_valid=0, key_data=00, retry count=0; cmd_ready=1 after release.

## Timing
- cmd_valid sampled high at edge N gives ps2_send_command=1 from N+1.
- ps2_cmd_sent at edge M gives ps2_send_command=0 from M+1.
- Final FA/AA/FC at edge K, or timeout expiry at edge K: done=1 and the new status during cycle K+1; cmd_ready=1 from K+2.
- key_valid is registered: asserted the cycle after ps2_rx_en, for one cycle.
- FE resend: ps2_send_command re-asserts the cycle after the FE is received.
- ps2_rx_en in the same cycle as cmd_valid in IDLE: the byte is forwarded and the command is accepted; both happen.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold it.

## Test plan
- ED + arg 07: sent pulse, FA, sent pulse, FA → ps2_command ED then 07; done with status 00; no key_valid for either FA.
- F4 without arg: FE, FE, then FA → F4 transmitted 3 times; status 00. Four FEs with MAX_RETRY=3 → status 01 after the 4th FE.
- FF reset: FA, then AA → status 00; same with FC → status 11; no response with BAT_TIMEOUT=100 → status 10 at cycle 101.
- No ACK with ACK_TIMEOUT=50 → done exactly 51 cycles after ack-state entry; status 10. ps2_cmd_timeout during SEND_CMD → status 10.
- Scancode 1C during ACK_CMD → key_data=1C, key_valid one cycle, command continues. FA in IDLE → forwarded.
- resetn low during SEND_ARG → ps2_send_command=0 immediately; after release cmd_ready=1, status 00, new command accepted.
